// File: rtl/window_spill_fill_if.sv
// Bundle between the register-window spill/fill engine and its CPU-side environment:
// window pointer register, windowed register file and data memory.
interface window_spill_fill_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic              call;
    logic              ret;
    logic [1:0]        cwp;
    logic              cwp_ld;
    logic [1:0]        cwp_next;
    logic              stall;
    logic [1:0]        rf_win;
    logic [2:0]        rf_idx;
    logic [DATA_W-1:0] rf_rdata;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              err;

    modport master (
        output call, ret, cwp, rf_rdata, mem_rdata,
        input  cwp_ld, cwp_next, stall, rf_win, rf_idx, rf_we, rf_wdata,
               mem_addr, mem_we, mem_wdata, err
    );

    modport slave (
        input  call, ret, cwp, rf_rdata, mem_rdata,
        output cwp_ld, cwp_next, stall, rf_win, rf_idx, rf_we, rf_wdata,
               mem_addr, mem_we, mem_wdata, err
    );
endinterface

// File: rtl/window_spill_fill.sv
// Register-window overflow/underflow engine: spills a live frame to memory on a call into
// an occupied window, fills it back on a return into a spilled one, and owns the CWP load.
module window_spill_fill #(
    parameter int              DATA_W      = 8,
    parameter int              ADDR_W      = 10,
    parameter logic [ADDR_W-1:0] SPILL_BASE = 10'h380,
    parameter int              SPILL_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    window_spill_fill_if.slave bus
);
    localparam int S_W = $clog2(SPILL_DEPTH + 1);
    localparam logic [S_W-1:0] DEPTH_S = S_W'(SPILL_DEPTH);

    typedef enum logic [1:0] {IDLE, SPILL, FILL, COMMIT} state_t;

    state_t         state_q, state_d;
    logic [2:0]     r_q, r_d;
    logic [S_W-1:0] s_q, s_d;
    logic [2:0]     idx_q, idx_d;
    logic [1:0]     t_q, t_d;

    logic           cwp_ld, stall, rf_we, mem_we, err, in_xfer;
    logic [1:0]     cwp_next;
    logic [S_W-1:0] s_sel;
    logic [ADDR_W-1:0] xfer_addr;

    // A fill reads back the topmost saved frame, one below the next free spill slot.
    assign s_sel     = (state_q == FILL) ? s_q - S_W'(1) : s_q;
    assign xfer_addr = SPILL_BASE + ADDR_W'({s_sel, 3'b000}) + ADDR_W'(idx_q);
    assign in_xfer   = (state_q == SPILL) || (state_q == FILL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            r_q     <= 3'd1;
            s_q     <= '0;
            idx_q   <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            t_q     <= t_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        s_d      = s_q;
        idx_d    = idx_q;
        t_d      = t_q;
        cwp_ld   = 1'b0;
        cwp_next = 2'd0;
        stall    = 1'b0;
        rf_we    = 1'b0;
        mem_we   = 1'b0;
        err      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.call && bus.ret) begin
                    err = 1'b1;
                end else if (bus.call) begin
                    if (r_q != 3'd4) begin
                        cwp_ld   = 1'b1;
                        cwp_next = bus.cwp + 2'd1;
                        r_d      = r_q + 3'd1;
                    end else if (s_q != DEPTH_S) begin
                        stall   = 1'b1;
                        state_d = SPILL;
                        t_d     = bus.cwp + 2'd1;
                        idx_d   = 3'd0;
                    end else begin
                        err = 1'b1;
                    end
                end else if (bus.ret) begin
                    if (r_q != 3'd1) begin
                        cwp_ld   = 1'b1;
                        cwp_next = bus.cwp - 2'd1;
                        r_d      = r_q - 3'd1;
                    end else if (s_q != '0) begin
                        stall   = 1'b1;
                        state_d = FILL;
                        t_d     = bus.cwp - 2'd1;
                        idx_d   = 3'd0;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            SPILL: begin
                stall  = 1'b1;
                mem_we = 1'b1;
                idx_d  = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    s_d     = s_q + S_W'(1);
                    state_d = COMMIT;
                end
            end
            FILL: begin
                stall = 1'b1;
                rf_we = 1'b1;
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    s_d     = s_q - S_W'(1);
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                cwp_ld   = 1'b1;
                cwp_next = t_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output is forced low while reset is asserted, even the IDLE combinational paths.
    assign bus.cwp_ld    = rst && cwp_ld;
    assign bus.cwp_next  = rst ? cwp_next : 2'd0;
    assign bus.stall     = rst && stall;
    assign bus.err       = rst && err;
    assign bus.rf_win    = (rst && in_xfer) ? t_q : 2'd0;
    assign bus.rf_idx    = (rst && in_xfer) ? idx_q : 3'd0;
    assign bus.mem_addr  = (rst && in_xfer) ? xfer_addr : {ADDR_W{1'b0}};
    assign bus.rf_we     = rst && rf_we;
    assign bus.rf_wdata  = (rst && rf_we) ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.mem_we    = rst && mem_we;
    assign bus.mem_wdata = (rst && mem_we) ? bus.rf_rdata : {DATA_W{1'b0}};
endmodule

// File: doc/window_spill_fill.md
Name: window_spill_fill

Overview:
- Register-window overflow/underflow engine. It sits beside the window pointer register and the windowed register file.
- On a call into a window still holding a live frame, it spills that window's 8 registers to a reserved data-memory area before advancing the current window pointer (CWP).
- On a return into a window whose frame was spilled, it fills the frame back from memory before retreating CWP.
- It stalls the CPU while transferring and owns the CWP load strobe.

Parameters:
- DATA_W, 8: register/memory data width.
- ADDR_W, 10: data-memory address width.
- SPILL_BASE, 10'h380: first word of the spill area.
- SPILL_DEPTH, 16: maximum spilled frames. The area spans SPILL_DEPTH*8 words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- call  in  1  decoded call instruction; held high while stall=1.
- ret  in  1  decoded return instruction; held high while stall=1.
- cwp  in  2  current window pointer from the window register.
- cwp_ld  out  1  load strobe to the window register.
- cwp_next  out  2  value loaded into the window register when cwp_ld=1.
- stall  out  1  freezes PC and all architectural writes.
- rf_win  out  2  window selected for the transfer port.
- rf_idx  out  3  register index within rf_win.
- rf_rdata  in  DATA_W  combinational read data from the register file.
- rf_we  out  1  register-file write enable (fill).
- rf_wdata  out  DATA_W  fill write data (equals mem_rdata).
- mem_addr  out  ADDR_W  data-memory address.
- mem_we  out  1  data-memory write enable (spill).
- mem_wdata  out  DATA_W  spill write data (equals rf_rdata).
- mem_rdata  in  DATA_W  combinational read data from data memory.
- err  out  1  one-cycle pulse on an illegal or unserviceable request.

Behaviour:
- Reset:
  - rst=0 asynchronously forces state=IDLE, resident count R=1, spilled count S=0, idx=0.
  - All outputs are 0 during reset, including cwp_next.
  - Reset mid-transfer abandons it; partially written spill words are don't-care.
- State machine: IDLE, SPILL, FILL, COMMIT.
- IDLE, call=1 and ret=1 together: err=1; no other effect.
- IDLE, call, R<4: cwp_ld=1, cwp_next=cwp+1 (mod 4), stall=0, R++. Combinational; zero stall.
- IDLE, call, R=4, S<SPILL_DEPTH: stall=1, go to SPILL with target window T=cwp+1 and idx=0.
- IDLE, call, R=4, S=SPILL_DEPTH: err=1, cwp_ld=0, stall=0; call dropped.
- IDLE, ret, R>1: cwp_ld=1, cwp_next=cwp-1 (mod 4), R--.
- IDLE, ret, R=1, S>0: stall=1, go to FILL with T=cwp-1 and idx=0.
- IDLE, ret, R=1, S=0: err=1, no load.
- SPILL (8 cycles, idx 0..7), each cycle:
  - stall=1, rf_win=T, rf_idx=idx.
  - mem_we=1, mem_addr=SPILL_BASE+S*8+idx, mem_wdata=rf_rdata.
  - After idx=7: S++ and go to COMMIT. R stays 4.
- FILL (8 cycles, idx 0..7), each cycle:
  - stall=1, rf_win=T, rf_idx=idx.
  - rf_we=1, mem_addr=SPILL_BASE+(S-1)*8+idx, rf_wdata=mem_rdata.
  - After idx=7: S-- and go to COMMIT. R stays 1.
- COMMIT (1 cycle): stall=0, cwp_ld=1, cwp_next=T; go to IDLE. call/ret are ignored in COMMIT.
- Spill/fill latency: request cycle + 8 transfer cycles = 9 stall cycles, then the COMMIT cycle completes the instruction.
- Spill order: LIFO. The most recent spill is filled first.
- Address arithmetic: truncated to ADDR_W bits.
- Strobes: mem_we and rf_we are never both 1. Both are 0 outside SPILL/FILL.
- Protocol violations: call/ret changing while stall=1 are ignored.
- Window 0 is not special. All windows are treated uniformly with mod-4 wrap.

Test Plan:
- Reset with cwp=0; three calls on consecutive cycles -> cwp_ld each cycle, cwp_next 1,2,3; stall never 1; R=4.
- Fourth call with cwp=3 -> stall for 9 cycles; mem_we at 0x380..0x387 with window 0's registers in order; COMMIT cycle cwp_ld=1, cwp_next=0; S=1.
- Then three rets (cwp 0->3->2->1) with no stall; fourth ret at cwp=1 -> FILL into window 0 from 0x380..0x387; data round-trips; COMMIT cwp_next=0; S=0.
- Ret at R=1, S=0 -> err pulse for exactly 1 cycle, no cwp_ld, no stall. Call and ret together -> err.
- Fill the spill area to SPILL_DEPTH=16 frames (last frame at 0x3F8..0x3FF); 17th spill-requiring call -> err, no memory write.
- Assert rst low during SPILL idx=4 -> outputs 0 immediately; after release, call increments from R=1 with no stall.
